frog_input_ctrl: RTL and testbench

Keyboard-side front end for the frog movers. Converts the sampled 8-bit keycode into single-frame direction pulses (up/down/left/right) with hold-to-repeat, plus a latched one-hot frog selection (frog_1_key..frog_3_key). All outputs are registered on frame_clk and feed the three frog instances and the frog-position mux. Also provides a saturating move counter for the score/HUD logic.

---
 rtl/frog_input_ctrl.sv | 155 +++++++++++++++
 tb/tb_frog_input_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/frog_input_ctrl.sv
// Keyboard front end for the frog movers: turns the sampled keycode into one-frame
// direction pulses with hold-to-repeat, a latched one-hot frog selection and a move count.
module frog_input_ctrl #(
  parameter logic [7:0] KEY_UP       = 8'h1A,
  parameter logic [7:0] KEY_DOWN     = 8'h16,
  parameter logic [7:0] KEY_LEFT     = 8'h04,
  parameter logic [7:0] KEY_RIGHT    = 8'h07,
  parameter logic [7:0] KEY_F1       = 8'h1E,
  parameter logic [7:0] KEY_F2       = 8'h1F,
  parameter logic [7:0] KEY_F3       = 8'h20,
  parameter int         REPEAT_DELAY = 20,
  parameter int         REPEAT_RATE  = 8
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic        dead_frog,
  input  logic        win_game,
  input  logic        lose_game,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic        frog_1_key,
  output logic        frog_2_key,
  output logic        frog_3_key,
  output logic [15:0] moves_made
);

  localparam logic [7:0] DELAY_LOAD = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_LOAD  = 8'(REPEAT_RATE);
  localparam bit         REPEAT_EN  = (REPEAT_RATE != 0);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t      state, state_n;
  logic [7:0]  key_q;
  logic [2:0]  sel, sel_next;
  logic [1:0]  dir_lat, dir_n, key_dir;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  pulse;
  logic        key_is_dir, dir_req, lock, sel_change, emit;

  assign lock       = win_game | lose_game;
  assign dir_req    = key_is_dir && (sel != 3'b000);
  assign sel_change = (sel_next != sel);

  // Direction codes: 0 up, 1 down, 2 left, 3 right.
  always_comb begin
    key_is_dir = 1'b1;
    key_dir    = 2'd0;
    case (key_q)
      KEY_UP:    key_dir = 2'd0;
      KEY_DOWN:  key_dir = 2'd1;
      KEY_LEFT:  key_dir = 2'd2;
      KEY_RIGHT: key_dir = 2'd3;
      default:   key_is_dir = 1'b0;
    endcase
  end

  // Selection reacts to the raw keycode so dead_frog can win over a same-cycle select key.
  always_comb begin
    sel_next = sel;
    if (lock || dead_frog)
      sel_next = 3'b000;
    else if (keycode == KEY_F1)
      sel_next = 3'b001;
    else if (keycode == KEY_F2)
      sel_next = 3'b010;
    else if (keycode == KEY_F3)
      sel_next = 3'b100;
  end

  always_comb begin
    state_n = state;
    dir_n   = dir_lat;
    cnt_n   = cnt;
    emit    = 1'b0;
    if (lock || sel_change) begin
      state_n = IDLE;
      cnt_n   = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dir_req) begin
            emit    = 1'b1;
            dir_n   = key_dir;
            cnt_n   = DELAY_LOAD;
            state_n = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!dir_req) begin
            state_n = IDLE;
          end else if (key_dir != dir_lat) begin
            emit    = 1'b1;
            dir_n   = key_dir;
            cnt_n   = DELAY_LOAD;
            state_n = HOLD;
          end else if (state == HOLD) begin
            // The decrement that would reach zero is the entry into REPEAT.
            if (cnt <= 8'd1) begin
              state_n = REPEAT;
              cnt_n   = 8'd0;
              if (REPEAT_EN) begin
                emit  = 1'b1;
                cnt_n = RATE_LOAD;
              end
            end else begin
              cnt_n = cnt - 8'd1;
            end
          end else if (REPEAT_EN) begin
            if (cnt <= 8'd1) begin
              emit  = 1'b1;
              cnt_n = RATE_LOAD;
            end else begin
              cnt_n = cnt - 8'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      key_q      <= 8'h00;
      sel        <= 3'b000;
      state      <= IDLE;
      dir_lat    <= 2'd0;
      cnt        <= 8'd0;
      pulse      <= 4'b0000;
      moves_made <= 16'h0000;
    end else begin
      key_q   <= lock ? 8'h00 : keycode;
      sel     <= sel_next;
      state   <= state_n;
      dir_lat <= dir_n;
      cnt     <= cnt_n;
      pulse   <= emit ? (4'b0001 << dir_n) : 4'b0000;
      if (emit && (moves_made != 16'hFFFF))
        moves_made <= moves_made + 16'd1;
    end
  end

  assign up         = pulse[0];
  assign down       = pulse[1];
  assign left       = pulse[2];
  assign right      = pulse[3];
  assign frog_1_key = sel[0];
  assign frog_2_key = sel[1];
  assign frog_3_key = sel[2];

endmodule

// File: tb/tb_frog_input_ctrl.sv
// Directed bench for frog_input_ctrl: a vector table for selection/lock/decode
// plus hand-written sequences for the hold-to-repeat timing.
module tb_frog_input_ctrl;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  keycode = 8'h00;
  logic        dead_frog = 1'b0;
  logic        win_game = 1'b0;
  logic        lose_game = 1'b0;
  logic        up, down, left, right;
  logic        frog_1_key, frog_2_key, frog_3_key;
  logic [15:0] moves_made;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0]  key;
    logic        dead;
    logic        win;
    logic        lose;
    logic [3:0]  pulse;
    logic [2:0]  sel;
    logic [15:0] moves;
  } vec_t;

  vec_t vecs[25];

  frog_input_ctrl dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .dead_frog  (dead_frog),
    .win_game   (win_game),
    .lose_game  (lose_game),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .frog_1_key (frog_1_key),
    .frog_2_key (frog_2_key),
    .frog_3_key (frog_3_key),
    .moves_made (moves_made)
  );

  always #5 frame_clk = ~frame_clk;

  wire [3:0] pulses   = {right, left, down, up};
  wire [2:0] sel_bits = {frog_3_key, frog_2_key, frog_1_key};

  task automatic applyStimulus(input logic [7:0] k, input logic d, input logic w, input logic l);
    keycode   = k;
    dead_frog = d;
    win_game  = w;
    lose_game = l;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reset is applied with a select key present to show that reset wins on the same edge.
  task automatic do_reset();
    Reset = 1'b1;
    applyStimulus(8'h1E, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'h1E, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b001, 16'd0};
    vecs[1]  = '{8'h1A, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b001, 16'd0};
    vecs[2]  = '{8'h1A, 1'b0, 1'b0, 1'b0, 4'b0001, 3'b001, 16'd1};
    vecs[3]  = '{8'h1A, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b001, 16'd1};
    vecs[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b001, 16'd1};
    vecs[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b001, 16'd1};
    vecs[6]  = '{8'h1F, 1'b1, 1'b0, 1'b0, 4'b0000, 3'b000, 16'd1};
    vecs[7]  = '{8'h1A, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 16'd1};
    vecs[8]  = '{8'h1A, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 16'd1};
    vecs[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 16'd1};
    vecs[10] = '{8'h1F, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b010, 16'd1};
    vecs[11] = '{8'h07, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b010, 16'd1};
    vecs[12] = '{8'h07, 1'b0, 1'b0, 1'b0, 4'b1000, 3'b010, 16'd2};
    vecs[13] = '{8'h16, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b010, 16'd2};
    vecs[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 4'b0010, 3'b010, 16'd3};
    vecs[15] = '{8'h04, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b010, 16'd3};
    vecs[16] = '{8'h20, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b100, 16'd3};
    vecs[17] = '{8'h04, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b100, 16'd3};
    vecs[18] = '{8'h04, 1'b0, 1'b1, 1'b0, 4'b0000, 3'b000, 16'd3};
    vecs[19] = '{8'h04, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 16'd3};
    vecs[20] = '{8'h20, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b100, 16'd3};
    vecs[21] = '{8'h1A, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b100, 16'd3};
    vecs[22] = '{8'h1A, 1'b0, 1'b0, 1'b0, 4'b0001, 3'b100, 16'd4};
    vecs[23] = '{8'h00, 1'b1, 1'b0, 1'b0, 4'b0000, 3'b000, 16'd4};
    vecs[24] = '{8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 16'd4};

    do_reset();
    checkOutput("reset pulses", {28'd0, pulses}, 32'h0);
    checkOutput("reset sel", {29'd0, sel_bits}, 32'h0);
    checkOutput("reset moves", {16'd0, moves_made}, 32'h0);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].key, vecs[i].dead, vecs[i].win, vecs[i].lose);
      checkOutput($sformatf("vec%0d pulse", i), {28'd0, pulses}, {28'd0, vecs[i].pulse});
      checkOutput($sformatf("vec%0d sel", i), {29'd0, sel_bits}, {29'd0, vecs[i].sel});
      checkOutput($sformatf("vec%0d moves", i), {16'd0, moves_made}, {16'd0, vecs[i].moves});
    end

    // No frog selected: a held direction key must never move anything.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      applyStimulus(8'h07, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("nosel t%0d", i), {28'd0, pulses}, 32'h0);
    end
    checkOutput("nosel moves", {16'd0, moves_made}, 32'd0);

    // Held down key: first pulse, auto-repeat after 20 frames, then every 8.
    do_reset();
    applyStimulus(8'h1F, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 45; i++) begin
      logic [3:0] exp_p;
      applyStimulus((i < 40) ? 8'h16 : 8'h00, 1'b0, 1'b0, 1'b0);
      exp_p = (i == 1 || i == 21 || i == 29 || i == 37) ? 4'b0010 : 4'b0000;
      checkOutput($sformatf("repeat t%0d", i), {28'd0, pulses}, {28'd0, exp_p});
    end
    checkOutput("repeat moves", {16'd0, moves_made}, 32'd4);

    // Direction change mid-hold: immediate pulse and a restarted repeat delay.
    do_reset();
    applyStimulus(8'h20, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 31; i++) begin
      logic [3:0] exp_p;
      applyStimulus((i < 5) ? 8'h04 : 8'h07, 1'b0, 1'b0, 1'b0);
      exp_p = (i == 1) ? 4'b0100 : ((i == 6 || i == 26) ? 4'b1000 : 4'b0000);
      checkOutput($sformatf("switch t%0d", i), {28'd0, pulses}, {28'd0, exp_p});
    end
    checkOutput("switch moves", {16'd0, moves_made}, 32'd3);

    // Lock during a hold clears selection; the move count survives it.
    do_reset();
    applyStimulus(8'h1E, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h1A, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("prelock t%0d", i), {28'd0, pulses}, (i == 1) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h1A, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("lock pulse t%0d", i), {28'd0, pulses}, 32'h0);
      checkOutput($sformatf("lock sel t%0d", i), {29'd0, sel_bits}, 32'h0);
    end
    checkOutput("lock moves", {16'd0, moves_made}, 32'd1);
    applyStimulus(8'h1E, 1'b0, 1'b0, 1'b0);
    checkOutput("unlock sel", {29'd0, sel_bits}, 32'h1);
    applyStimulus(8'h1A, 1'b0, 1'b0, 1'b0);
    checkOutput("unlock wait", {28'd0, pulses}, 32'h0);
    applyStimulus(8'h1A, 1'b0, 1'b0, 1'b0);
    checkOutput("unlock pulse", {28'd0, pulses}, 32'h1);
    checkOutput("unlock moves", {16'd0, moves_made}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
